// File: rtl/reg_wb_arbiter_if.sv
// Writeback arbiter bus: two requester channels (ALU, load) with valid/ready,
// the hold control, and the register-file write stage outputs.
// slave  : seen by the arbiter.
// master : seen by whatever drives the requests and consumes the write port.
interface reg_wb_arbiter_if #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int CNT_WIDTH          = 16
);
  localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;

  // ALU writeback requester
  logic                         alu_valid_in;
  logic [REG_MEM_DEPTH_POW-1:0] alu_rd_in;
  logic [REG_DATA_WIDTH-1:0]    alu_data_in;
  logic                         alu_ready_out;

  // Load writeback requester
  logic                         mem_valid_in;
  logic [REG_MEM_DEPTH_POW-1:0] mem_rd_in;
  logic [REG_DATA_WIDTH-1:0]    mem_data_in;
  logic                         mem_ready_out;

  // Arbitration freeze
  logic                         wb_hold_in;

  // Register-file write port and perf counter
  logic [REG_MEM_DEPTH_POW-1:0] rd_out;
  logic [REG_DATA_WIDTH-1:0]    data_write_out;
  logic                         write_en_out;
  logic [CNT_WIDTH-1:0]         conflict_cnt_out;

  modport slave (
    input  alu_valid_in, alu_rd_in, alu_data_in,
    input  mem_valid_in, mem_rd_in, mem_data_in,
    input  wb_hold_in,
    output alu_ready_out, mem_ready_out,
    output rd_out, data_write_out, write_en_out, conflict_cnt_out
  );

  modport master (
    output alu_valid_in, alu_rd_in, alu_data_in,
    output mem_valid_in, mem_rd_in, mem_data_in,
    output wb_hold_in,
    input  alu_ready_out, mem_ready_out,
    input  rd_out, data_write_out, write_en_out, conflict_cnt_out
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter between ALU and load writeback.
// Readies are combinational from the valids, hold and the last grant; the winner
// is registered into an output stage that drives the register file directly.
// A saturating counter records cycles where both requesters competed.
// Build option: define WB_FIXED_PRIO_EN for fixed priority (load always wins a
// conflict); otherwise conflicts are resolved round-robin.
module reg_wb_arbiter #(
  parameter int REG_DATA_WIDTH_POW = 6,
  parameter int REG_MEM_DEPTH_POW  = 5,
  parameter int CNT_WIDTH          = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  reg_wb_arbiter_if.slave   bus
);
  localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic                         w_active;
  logic                         w_conflict;
  logic                         w_alu_wins_conflict;
  logic                         w_alu_grant;
  logic                         w_mem_grant;

  logic [REG_MEM_DEPTH_POW-1:0] r_rd;
  logic [REG_DATA_WIDTH-1:0]    r_data;
  logic                         r_write_en;
  logic [CNT_WIDTH-1:0]         r_conflict_cnt;

`ifndef WB_FIXED_PRIO_EN
  typedef enum logic {GrantAlu, GrantMem} grant_e;
  grant_e r_last_grant;
`endif

  // Grant decision: nothing is granted in reset or while held.
  always_comb begin
    w_active   = !rst_in && !bus.wb_hold_in;
    w_conflict = w_active && bus.alu_valid_in && bus.mem_valid_in;
`ifdef WB_FIXED_PRIO_EN
    w_alu_wins_conflict = 1'b0;
`else
    w_alu_wins_conflict = (r_last_grant == GrantMem);
`endif
    w_alu_grant = w_active && bus.alu_valid_in && (!bus.mem_valid_in || w_alu_wins_conflict);
    w_mem_grant = w_active && bus.mem_valid_in && (!bus.alu_valid_in || !w_alu_wins_conflict);
  end

`ifndef WB_FIXED_PRIO_EN
  // Round-robin pointer: remembers who won most recently; idle cycles leave it alone.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last_grant <= GrantMem;
    end else if (w_alu_grant) begin
      r_last_grant <= GrantAlu;
    end else if (w_mem_grant) begin
      r_last_grant <= GrantMem;
    end
  end
`endif

  // Output stage: capture the winner; x0 targets are accepted but never write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd       <= '0;
      r_data     <= '0;
      r_write_en <= 1'b0;
    end else begin
      r_write_en <= 1'b0;
      if (w_alu_grant) begin
        r_rd       <= bus.alu_rd_in;
        r_data     <= bus.alu_data_in;
        r_write_en <= |bus.alu_rd_in;
      end else if (w_mem_grant) begin
        r_rd       <= bus.mem_rd_in;
        r_data     <= bus.mem_data_in;
        r_write_en <= |bus.mem_rd_in;
      end
    end
  end

  // Conflict counter: saturates at all-ones instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != CntMax)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.alu_ready_out    = w_alu_grant;
  assign bus.mem_ready_out    = w_mem_grant;
  assign bus.rd_out           = r_rd;
  assign bus.data_write_out   = r_data;
  assign bus.write_en_out     = r_write_en;
  assign bus.conflict_cnt_out = r_conflict_cnt;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios with literal expectations, then
// constrained-random traffic checked every cycle against a behavioural model.
module tb_reg_wb_arbiter;
  localparam int DP = 6;
  localparam int AP = 5;
  localparam int CW = 4;
  localparam int DW = 1 << DP;
  localparam int CntTop = (1 << CW) - 1;
`ifdef WB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  localparam int ReqNone = 0;
  localparam int ReqAlu  = 1;
  localparam int ReqMem  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.REG_DATA_WIDTH_POW(DP), .REG_MEM_DEPTH_POW(AP), .CNT_WIDTH(CW)) bus ();

  reg_wb_arbiter #(
    .REG_DATA_WIDTH_POW(DP),
    .REG_MEM_DEPTH_POW (AP),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who is owed the next conflict, and what the write port shows.
  int              m_prefer = ReqAlu;
  logic [AP-1:0]   m_rd;
  logic [DW-1:0]   m_data;
  logic            m_we;
  int              m_cnt;
  bit              m_alu_acc = 1'b0;
  bit              m_mem_acc = 1'b0;
  bit              m_valid   = 1'b0;

  function automatic int pick();
    if (rst || bus.wb_hold_in) return ReqNone;
    if (bus.alu_valid_in && bus.mem_valid_in) return FixedPrio ? ReqMem : m_prefer;
    if (bus.alu_valid_in) return ReqAlu;
    if (bus.mem_valid_in) return ReqMem;
    return ReqNone;
  endfunction

  always @(posedge clk) begin
    int g;
    g = pick();
    m_alu_acc = (g == ReqAlu);
    m_mem_acc = (g == ReqMem);
    if (rst) begin
      m_rd     = '0;
      m_data   = '0;
      m_we     = 1'b0;
      m_cnt    = 0;
      m_prefer = ReqAlu;
      m_valid  = 1'b1;
    end else begin
      m_we = 1'b0;
      if (g == ReqAlu) begin
        m_rd = bus.alu_rd_in; m_data = bus.alu_data_in; m_we = (bus.alu_rd_in != 0);
        m_prefer = ReqMem;
      end else if (g == ReqMem) begin
        m_rd = bus.mem_rd_in; m_data = bus.mem_data_in; m_we = (bus.mem_rd_in != 0);
        m_prefer = ReqAlu;
      end
      if (bus.alu_valid_in && bus.mem_valid_in && !bus.wb_hold_in && m_cnt < CntTop) m_cnt++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int g;
    if (m_valid) begin
      g = pick();
      chk("alu_ready", bus.alu_ready_out, g == ReqAlu);
      chk("mem_ready", bus.mem_ready_out, g == ReqMem);
      chk("write_en", bus.write_en_out, m_we);
      chk("rd_out", bus.rd_out, m_rd);
      chk("data_write", bus.data_write_out, m_data);
      chk("conflict_cnt", bus.conflict_cnt_out, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [AP-1:0] rd, input logic [DW-1:0] d);
    bus.alu_valid_in = v; bus.alu_rd_in = rd; bus.alu_data_in = d;
  endtask

  task automatic set_mem(input logic v, input logic [AP-1:0] rd, input logic [DW-1:0] d);
    bus.mem_valid_in = v; bus.mem_rd_in = rd; bus.mem_data_in = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_hold_in = 1'b0;
    set_mem(1'b0, '0, '0);
    // A request present during reset must not be accepted.
    set_alu(1'b1, 5'd5, 64'hDEAD);
    @(negedge clk);
    chk("ready_in_reset", bus.alu_ready_out, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("reset_we", bus.write_en_out, 1'b0);
    chk("reset_rd", bus.rd_out, 0);
    chk("reset_data", bus.data_write_out, 0);
    chk("reset_cnt", bus.conflict_cnt_out, 0);

    // ALU-only request
    @(negedge clk);
    chk("alu_only_ready", bus.alu_ready_out, 1'b1);
    tick();
    set_alu(1'b0, '0, '0);
    chk("alu_only_we", bus.write_en_out, 1'b1);
    chk("alu_only_rd", bus.rd_out, 5);
    chk("alu_only_data", bus.data_write_out, 64'hDEAD);
    tick();
    chk("alu_only_drain", bus.write_en_out, 1'b0);

    // Conflict straight after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_alu(1'b1, 5'd3, 64'h33);
    set_mem(1'b1, 5'd7, 64'h77);
    tick();
    chk("conflict1_rd", bus.rd_out, FixedPrio ? 7 : 3);
    chk("conflict1_cnt", bus.conflict_cnt_out, 1);
    tick();
    set_mem(1'b0, '0, '0);
    chk("conflict2_rd", bus.rd_out, 7);
    chk("conflict2_cnt", bus.conflict_cnt_out, 2);
    tick();
    set_alu(1'b0, '0, '0);
    chk("conflict3_rd", bus.rd_out, 3);

    // Load to x0: accepted, no write
    set_mem(1'b1, 5'd0, 64'h1234);
    @(negedge clk);
    chk("x0_ready", bus.mem_ready_out, 1'b1);
    tick();
    set_mem(1'b0, '0, '0);
    chk("x0_we", bus.write_en_out, 1'b0);
    chk("x0_data", bus.data_write_out, 64'h1234);

    // Hold with both valid, then release
    bus.wb_hold_in = 1'b1;
    set_alu(1'b1, 5'd10, 64'hA);
    set_mem(1'b1, 5'd11, 64'hB);
    repeat (3) begin
      @(negedge clk);
      chk("hold_alu_ready", bus.alu_ready_out, 1'b0);
      chk("hold_mem_ready", bus.mem_ready_out, 1'b0);
      tick();
      chk("hold_we", bus.write_en_out, 1'b0);
      chk("hold_cnt", bus.conflict_cnt_out, 2);
    end
    bus.wb_hold_in = 1'b0;
    @(negedge clk);
    chk("release_alu_ready", bus.alu_ready_out, FixedPrio ? 1'b0 : 1'b1);
    tick();
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);
    chk("release_cnt", bus.conflict_cnt_out, 3);
    chk("release_rd", bus.rd_out, FixedPrio ? 11 : 10);

    // Reset right after a grant discards the write
    set_alu(1'b1, 5'd9, 64'h99);
    tick();
    set_alu(1'b0, '0, '0);
    rst = 1'b1;
    chk("pre_reset_we", bus.write_en_out, 1'b1);
    tick();
    rst = 1'b0;
    chk("mid_reset_we", bus.write_en_out, 1'b0);
    chk("mid_reset_cnt", bus.conflict_cnt_out, 0);

    // Saturation: 2^CW + 3 conflict cycles
    set_alu(1'b1, 5'd1, 64'h1);
    set_mem(1'b1, 5'd2, 64'h2);
    repeat ((1 << CW) + 3) tick();
    chk("saturate_cnt", bus.conflict_cnt_out, 15);
    set_alu(1'b0, '0, '0);
    set_mem(1'b0, '0, '0);
    tick();

    // Random traffic; a requester keeps its request stable until accepted.
    repeat (3000) begin
      rst = ($urandom_range(99) == 0);
      bus.wb_hold_in = ($urandom_range(9) == 0);
      if (!bus.alu_valid_in || m_alu_acc)
        set_alu($urandom_range(9) < 7, AP'($urandom), {$urandom, $urandom});
      if (!bus.mem_valid_in || m_mem_acc)
        set_mem($urandom_range(9) < 7, AP'($urandom), {$urandom, $urandom});
      tick();
    end

    rst = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
